bsg_chip_mem_slave: RTL and testbench

Memory-side endpoint that sits directly downstream of the chip's memory command port. It accepts one memory command message at a time and services it from an on-chip synchronous block RAM. It returns exactly one memory response message per command. It serves as the backing store for bring-up and simulation, so that the core's cache-fill and uncached traffic terminates inside the toplevel.

---
 rtl/bsg_chip_mem_slave.sv | 128 ++++++++++++
 tb/tb_bsg_chip_mem_slave.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_chip_mem_slave.sv
// bsg_chip_mem_slave: single-outstanding memory endpoint backed by an on-chip block RAM
// Define BSG_CHIP_MEM_SLAVE_ZERO_INIT_EN to sweep the RAM to zero after every reset.
module bsg_chip_mem_slave #(
    parameter int paddr_width_p   = 40,
    parameter int block_width_p   = 512,
    parameter int payload_width_p = 16,
    parameter int els_p           = 1024,
    localparam int msg_width_lp   = 4 + paddr_width_p + 3 + payload_width_p + block_width_p
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [msg_width_lp-1:0] mem_cmd_i,
    input  logic                    mem_cmd_v_i,
    output logic                    mem_cmd_ready_o,
    output logic [msg_width_lp-1:0] mem_resp_o,
    output logic                    mem_resp_v_o,
    input  logic                    mem_resp_yumi_i
);
    localparam int bytes_lp = block_width_p / 8;
    localparam int off_w_lp = $clog2(bytes_lp);
    localparam int idx_w_lp = $clog2(els_p);
    localparam logic [3:0] type_rd_lp    = 4'd0;
    localparam logic [3:0] type_wr_lp    = 4'd1;
    localparam logic [3:0] type_uc_rd_lp = 4'd2;
    localparam logic [3:0] type_uc_wr_lp = 4'd3;

    typedef enum logic [1:0] {
        e_idle,
        e_access,
        e_resp
`ifdef BSG_CHIP_MEM_SLAVE_ZERO_INIT_EN
        , e_clear
`endif
    } state_e;

`ifdef BSG_CHIP_MEM_SLAVE_ZERO_INIT_EN
    localparam state_e reset_state_lp = e_clear;
`else
    localparam state_e reset_state_lp = e_idle;
`endif

    state_e                     state_r, state_n;
    logic [msg_width_lp-1:0]    cmd_r;
    logic [3:0]                 cmd_type;
    logic [paddr_width_p-1:0]   cmd_addr;
    logic [2:0]                 cmd_size;
    logic [payload_width_p-1:0] cmd_payload;
    logic [block_width_p-1:0]   cmd_data;
    logic [block_width_p-1:0]   mem_r [els_p];
    logic [block_width_p-1:0]   rd_data_r;
    logic [block_width_p-1:0]   uc_wdata, uc_rdata, ram_wdata, resp_data;
    logic [bytes_lp-1:0]        uc_be, ram_be;
    logic [off_w_lp-1:0]        fmask, aoff;
    logic [idx_w_lp-1:0]        ram_idx;
    logic                       ram_we, ram_re;

    assign {cmd_data, cmd_payload, cmd_size, cmd_addr, cmd_type} = cmd_r;

    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) state_r <= reset_state_lp;
        else            state_r <= state_n;

`ifdef BSG_CHIP_MEM_SLAVE_ZERO_INIT_EN
    logic [idx_w_lp-1:0] clr_cnt_r;

    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i)              clr_cnt_r <= '0;
        else if (state_r == e_clear) clr_cnt_r <= clr_cnt_r + idx_w_lp'(1);
`endif

    always_comb begin
        state_n = state_r;
        case (state_r)
            e_idle:   state_n = mem_cmd_v_i ? e_access : e_idle;
            e_access: state_n = e_resp;
            e_resp:   state_n = mem_resp_yumi_i ? e_idle : e_resp;
`ifdef BSG_CHIP_MEM_SLAVE_ZERO_INIT_EN
            e_clear:  state_n = (clr_cnt_r == '1) ? e_idle : e_clear;
`endif
            default:  state_n = e_idle;
        endcase
    end

    always_comb begin
        mem_cmd_ready_o = reset_n_i && state_r == e_idle;
        mem_resp_v_o    = reset_n_i && state_r == e_resp;
        mem_resp_o      = mem_resp_v_o ? {resp_data, cmd_payload, cmd_size, cmd_addr, cmd_type} : '0;
    end

    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i)                          cmd_r <= '0;
        else if (mem_cmd_ready_o && mem_cmd_v_i) cmd_r <= mem_cmd_i;

    // Sizes beyond the block clamp to a full-block field mask.
    assign fmask = (32'(cmd_size) >= off_w_lp) ? '1 : off_w_lp'((32'd1 << cmd_size) - 32'd1);
    assign aoff  = cmd_addr[off_w_lp-1:0] & ~fmask;

    // Writes replicate the low field across the block; reads fold the aligned field back out.
    always_comb begin
        uc_wdata = '0;
        uc_rdata = '0;
        uc_be    = '0;
        for (int b = 0; b < bytes_lp; b++) begin
            uc_wdata[8*b +: 8] = cmd_data[8*(b & int'(fmask)) +: 8];
            uc_rdata[8*b +: 8] = rd_data_r[8*int'(aoff | (off_w_lp'(b) & fmask)) +: 8];
            uc_be[b]           = (off_w_lp'(b) & ~fmask) == aoff;
        end
    end

    assign ram_idx   = cmd_addr[off_w_lp +: idx_w_lp];
    assign ram_we    = state_r == e_access && (cmd_type == type_wr_lp || cmd_type == type_uc_wr_lp);
    assign ram_re    = state_r == e_access && (cmd_type == type_rd_lp || cmd_type == type_uc_rd_lp);
    assign ram_wdata = (cmd_type == type_wr_lp) ? cmd_data : uc_wdata;
    assign ram_be    = (cmd_type == type_wr_lp) ? '1 : uc_be;
    assign resp_data = (cmd_type == type_rd_lp)    ? rd_data_r :
                       (cmd_type == type_uc_rd_lp) ? uc_rdata  : '0;

    always_ff @(posedge clk_i) begin
`ifdef BSG_CHIP_MEM_SLAVE_ZERO_INIT_EN
        if (state_r == e_clear) mem_r[clr_cnt_r] <= '0;
`endif
        if (ram_we)
            for (int b = 0; b < bytes_lp; b++)
                if (ram_be[b]) mem_r[ram_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
        if (ram_re) rd_data_r <= mem_r[ram_idx];
    end

endmodule

// File: tb/tb_bsg_chip_mem_slave.sv
// tb_bsg_chip_mem_slave: directed scenarios for the block-RAM memory endpoint
// Define BSG_CHIP_MEM_SLAVE_ZERO_INIT_EN to also exercise the reset-time RAM sweep.
module tb_bsg_chip_mem_slave;
    localparam int MW = 4 + 40 + 3 + 16 + 512;
    localparam logic [3:0] RD = 4'd0, WR = 4'd1, UC_RD = 4'd2, UC_WR = 4'd3;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b0;
    logic [MW-1:0] mem_cmd_i = '0;
    logic          mem_cmd_v_i = 1'b0;
    logic          mem_cmd_ready_o;
    logic [MW-1:0] mem_resp_o;
    logic          mem_resp_v_o;
    logic          mem_resp_yumi_i = 1'b0;
    int            total = 0;
    int            bad = 0;

    always #5 clk_i = ~clk_i;

    bsg_chip_mem_slave dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .mem_cmd_i(mem_cmd_i), .mem_cmd_v_i(mem_cmd_v_i), .mem_cmd_ready_o(mem_cmd_ready_o),
        .mem_resp_o(mem_resp_o), .mem_resp_v_o(mem_resp_v_o), .mem_resp_yumi_i(mem_resp_yumi_i)
    );

    always @(posedge clk_i)
        assert (!(reset_n_i && mem_resp_yumi_i && !mem_resp_v_o))
        else $error("FAIL illegal_yumi yumi=1 while resp_v=0");

    function automatic logic [MW-1:0] mk(input logic [3:0] t, input logic [39:0] a,
                                         input logic [2:0] s, input logic [15:0] p,
                                         input logic [511:0] d);
        return {d, p, s, a, t};
    endfunction

    function automatic logic [511:0] dat(input logic [MW-1:0] r);
        return r[MW-1 -: 512];
    endfunction

    function automatic logic [62:0] hdr(input logic [MW-1:0] r);
        return r[62:0];
    endfunction

    // Issues one command, consumes its response; wt = cycles waited for ready, lat = cycles to resp_v (99 on timeout).
    task automatic do_cmd(input logic [MW-1:0] m, output logic [MW-1:0] r, output int wt, output int lat);
        wt = 0;
        lat = 99;
        r = '0;
        @(negedge clk_i);
        while (!mem_cmd_ready_o && wt < 50) begin
            @(negedge clk_i);
            wt++;
        end
        mem_cmd_i = m;
        mem_cmd_v_i = 1'b1;
        @(posedge clk_i);
        #1 mem_cmd_v_i = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_i);
            if (mem_resp_v_o) begin
                lat = i;
                break;
            end
        end
        if (lat != 99) begin
            r = mem_resp_o;
            mem_resp_yumi_i = 1'b1;
            @(posedge clk_i);
            #1 mem_resp_yumi_i = 1'b0;
        end
    endtask

    task automatic test_reset;
        int n;
        repeat (3) @(negedge clk_i);
        total++; if (mem_cmd_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", mem_cmd_ready_o); end
        total++; if (mem_resp_v_o !== 1'b0) begin bad++; $display("FAIL rst_resp_v got=%b exp=0", mem_resp_v_o); end
        total++; if (mem_resp_o !== '0) begin bad++; $display("FAIL rst_resp got=%h exp=0", mem_resp_o); end
        reset_n_i = 1'b1;
        #1 n = 0;
        while (!mem_cmd_ready_o && n < 3000) begin
            n++;
            @(negedge clk_i);
            #1;
        end
`ifdef BSG_CHIP_MEM_SLAVE_ZERO_INIT_EN
        total++; if (n !== 1024) begin bad++; $display("FAIL rst_clear_cycles got=%0d exp=1024", n); end
`else
        total++; if (n !== 0) begin bad++; $display("FAIL rst_idle_cycles got=%0d exp=0", n); end
`endif
    endtask

`ifdef BSG_CHIP_MEM_SLAVE_ZERO_INIT_EN
    task automatic test_zero_init;
        logic [MW-1:0] r;
        int wt, lat;
        do_cmd(mk(RD, 40'h01C0, 3'd6, 16'h0001, '0), r, wt, lat);
        total++; if (dat(r) !== '0) begin bad++; $display("FAIL zi_idx7 got=%h exp=0", dat(r)); end
        do_cmd(mk(RD, 40'hFFC0, 3'd6, 16'h0002, '0), r, wt, lat);
        total++; if (dat(r) !== '0) begin bad++; $display("FAIL zi_idx1023 got=%h exp=0", dat(r)); end
    endtask
`endif

    task automatic test_round_trip;
        logic [MW-1:0] r, m;
        logic [511:0] a5;
        int wt, lat;
        a5 = {64{8'hA5}};
        m = mk(WR, 40'h1040, 3'd6, 16'h1234, a5);
        do_cmd(m, r, wt, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL rt_wr_lat got=%0d exp=2", lat); end
        total++; if (dat(r) !== '0) begin bad++; $display("FAIL rt_wr_data got=%h exp=0", dat(r)); end
        total++; if (hdr(r) !== hdr(m)) begin bad++; $display("FAIL rt_wr_hdr got=%h exp=%h", hdr(r), hdr(m)); end
        m = mk(RD, 40'h1040, 3'd6, 16'hBEEF, '0);
        do_cmd(m, r, wt, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL rt_rd_lat got=%0d exp=2", lat); end
        total++; if (dat(r) !== a5) begin bad++; $display("FAIL rt_rd_data got=%h exp=%h", dat(r), a5); end
        total++; if (hdr(r) !== hdr(m)) begin bad++; $display("FAIL rt_rd_hdr got=%h exp=%h", hdr(r), hdr(m)); end
    endtask

    task automatic test_uc_merge;
        logic [MW-1:0] r;
        logic [511:0] e;
        int wt, lat;
        do_cmd(mk(WR, 40'h0000, 3'd6, 16'h0010, '1), r, wt, lat);
        do_cmd(mk(UC_WR, 40'h0003, 3'd0, 16'h0011, 512'h5A), r, wt, lat);
        total++; if (dat(r) !== '0) begin bad++; $display("FAIL uc_wr_data got=%h exp=0", dat(r)); end
        do_cmd(mk(UC_RD, 40'h0000, 3'd3, 16'h0012, '0), r, wt, lat);
        e = {8{64'hFFFFFFFF5AFFFFFF}};
        total++; if (lat !== 2) begin bad++; $display("FAIL uc_rd_lat got=%0d exp=2", lat); end
        total++; if (dat(r) !== e) begin bad++; $display("FAIL uc_rd_sz3 got=%h exp=%h", dat(r), e); end
        do_cmd(mk(UC_RD, 40'h0002, 3'd1, 16'h0013, '0), r, wt, lat);
        e = {32{16'h5AFF}};
        total++; if (dat(r) !== e) begin bad++; $display("FAIL uc_rd_sz1 got=%h exp=%h", dat(r), e); end
        do_cmd(mk(RD, 40'h0000, 3'd6, 16'h0014, '0), r, wt, lat);
        e = {{60{8'hFF}}, 32'h5AFFFFFF};
        total++; if (dat(r) !== e) begin bad++; $display("FAIL uc_block got=%h exp=%h", dat(r), e); end
        do_cmd(mk(UC_RD, 40'h0005, 3'd7, 16'h0015, '0), r, wt, lat);
        total++; if (dat(r) !== e) begin bad++; $display("FAIL uc_rd_clamp got=%h exp=%h", dat(r), e); end
        do_cmd(mk(UC_WR, 40'h0006, 3'd2, 16'h0016, 512'h11223344), r, wt, lat);
        do_cmd(mk(UC_RD, 40'h0004, 3'd2, 16'h0017, '0), r, wt, lat);
        e = {16{32'h11223344}};
        total++; if (dat(r) !== e) begin bad++; $display("FAIL uc_align got=%h exp=%h", dat(r), e); end
    endtask

    task automatic test_wrap;
        logic [MW-1:0] r;
        logic [511:0] p;
        int wt, lat;
        p = {16{32'hC0DE0005}};
        do_cmd(mk(WR, 40'h0140, 3'd6, 16'h0020, p), r, wt, lat);
        do_cmd(mk(RD, 40'h10140, 3'd6, 16'h0021, '0), r, wt, lat);
        total++; if (dat(r) !== p) begin bad++; $display("FAIL wrap_1024 got=%h exp=%h", dat(r), p); end
        do_cmd(mk(RD, 40'h80_0000_0140, 3'd6, 16'h0022, '0), r, wt, lat);
        total++; if (dat(r) !== p) begin bad++; $display("FAIL wrap_high got=%h exp=%h", dat(r), p); end
    endtask

    task automatic test_unsupported;
        logic [MW-1:0] r, m;
        logic [511:0] p;
        int wt, lat;
        p = {16{32'hC0DE0005}};
        m = mk(4'h7, 40'h0140, 3'd6, 16'h7777, '1);
        do_cmd(m, r, wt, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL unsup_lat got=%0d exp=2", lat); end
        total++; if (dat(r) !== '0) begin bad++; $display("FAIL unsup_data got=%h exp=0", dat(r)); end
        total++; if (hdr(r) !== hdr(m)) begin bad++; $display("FAIL unsup_hdr got=%h exp=%h", hdr(r), hdr(m)); end
        do_cmd(mk(RD, 40'h0140, 3'd6, 16'h0030, '0), r, wt, lat);
        total++; if (dat(r) !== p) begin bad++; $display("FAIL unsup_nowrite got=%h exp=%h", dat(r), p); end
    endtask

    task automatic test_back_to_back;
        logic [MW-1:0] r;
        int wt, lat;
        for (int i = 0; i < 3; i++) begin
            do_cmd(mk(RD, 40'h1040, 3'd6, 16'(i), '0), r, wt, lat);
            total++; if (wt !== 0) begin bad++; $display("FAIL b2b_ready_wait%0d got=%0d exp=0", i, wt); end
            total++; if (lat !== 2) begin bad++; $display("FAIL b2b_lat%0d got=%0d exp=2", i, lat); end
        end
    endtask

    task automatic test_back_pressure;
        logic [MW-1:0] r0;
        int lat;
        @(negedge clk_i);
        mem_cmd_i = mk(RD, 40'h1040, 3'd6, 16'h0BB0, '0);
        mem_cmd_v_i = 1'b1;
        @(posedge clk_i);
        #1 mem_cmd_v_i = 1'b0;
        lat = 99;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_i);
            if (mem_resp_v_o) begin lat = i; break; end
        end
        total++; if (lat !== 2) begin bad++; $display("FAIL bp_lat got=%0d exp=2", lat); end
        r0 = mem_resp_o;
        total++; if (dat(r0) !== {64{8'hA5}}) begin bad++; $display("FAIL bp_data got=%h exp=%h", dat(r0), {64{8'hA5}}); end
        mem_cmd_i = mk(RD, 40'h0140, 3'd6, 16'h0CC0, '0);
        mem_cmd_v_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            total++; if (mem_resp_o !== r0) begin bad++; $display("FAIL bp_stable%0d got=%h exp=%h", i, mem_resp_o, r0); end
            total++; if (mem_cmd_ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready%0d got=%b exp=0", i, mem_cmd_ready_o); end
        end
        mem_resp_yumi_i = 1'b1;
        @(posedge clk_i);
        #1 mem_resp_yumi_i = 1'b0;
        @(negedge clk_i);
        total++; if (mem_cmd_ready_o !== 1'b1) begin bad++; $display("FAIL bp_ready_after got=%b exp=1", mem_cmd_ready_o); end
        @(posedge clk_i);
        #1 mem_cmd_v_i = 1'b0;
        @(negedge clk_i);
        total++; if (mem_resp_v_o !== 1'b0) begin bad++; $display("FAIL bp2_early got=%b exp=0", mem_resp_v_o); end
        @(negedge clk_i);
        total++; if (mem_resp_v_o !== 1'b1) begin bad++; $display("FAIL bp2_v got=%b exp=1", mem_resp_v_o); end
        total++; if (mem_resp_o[62:47] !== 16'h0CC0) begin bad++; $display("FAIL bp2_payload got=%h exp=0cc0", mem_resp_o[62:47]); end
        total++; if (dat(mem_resp_o) !== {16{32'hC0DE0005}}) begin bad++; $display("FAIL bp2_data got=%h exp=%h", dat(mem_resp_o), {16{32'hC0DE0005}}); end
        if (mem_resp_v_o) begin
            mem_resp_yumi_i = 1'b1;
            @(posedge clk_i);
            #1 mem_resp_yumi_i = 1'b0;
        end
    endtask

    task automatic test_reset_mid_resp;
        int n;
        @(negedge clk_i);
        mem_cmd_i = mk(RD, 40'h1040, 3'd6, 16'hDEAD, '0);
        mem_cmd_v_i = 1'b1;
        @(posedge clk_i);
        #1 mem_cmd_v_i = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_i);
            if (mem_resp_v_o) break;
        end
        total++; if (mem_resp_v_o !== 1'b1) begin bad++; $display("FAIL mid_resp_v got=%b exp=1", mem_resp_v_o); end
        #2 reset_n_i = 1'b0;
        #1;
        total++; if (mem_resp_v_o !== 1'b0) begin bad++; $display("FAIL mid_async_v got=%b exp=0", mem_resp_v_o); end
        total++; if (mem_resp_o !== '0) begin bad++; $display("FAIL mid_async_resp got=%h exp=0", mem_resp_o); end
        total++; if (mem_cmd_ready_o !== 1'b0) begin bad++; $display("FAIL mid_async_ready got=%b exp=0", mem_cmd_ready_o); end
        repeat (3) @(negedge clk_i);
        reset_n_i = 1'b1;
        n = 0;
        while (!mem_cmd_ready_o && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        total++; if (mem_cmd_ready_o !== 1'b1) begin bad++; $display("FAIL mid_ready_back got=%b exp=1", mem_cmd_ready_o); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            total++; if (mem_resp_v_o !== 1'b0) begin bad++; $display("FAIL mid_stale%0d got=%b exp=0", i, mem_resp_v_o); end
        end
    endtask

    initial begin
        test_reset();
`ifdef BSG_CHIP_MEM_SLAVE_ZERO_INIT_EN
        test_zero_init();
`endif
        test_round_trip();
        test_uc_merge();
        test_wrap();
        test_unsupported();
        test_back_to_back();
        test_back_pressure();
        test_reset_mid_resp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
